inst_queue: RTL and testbench

Circular instruction FIFO between instruction fetch (IF) and the decoder (ID). It buffers fetched {inst, pc} pairs and presents the head entry to ID show-ahead. ID pops the head with a one-cycle enable. The whole queue flushes when the ROB signals a mispredict/clear.

---
 rtl/inst_queue_if.sv | 42 ++++
 rtl/inst_queue.sv | 72 +++++++
 tb/tb_inst_queue.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
// Queue side uses slave; the fetch/decode side uses master.
interface inst_queue_if #(
    parameter int PTR_W = 4
);
    logic             IF_valid;
    logic [31:0]      IF_inst;
    logic [31:0]      IF_pc;
    logic             queue_is_full;
    logic             queue_almost_full;
    logic             ID_enable;
    logic             queue_is_empty;
    logic [31:0]      ID_inst;
    logic [31:0]      ID_pc;
    logic [PTR_W:0]   queue_count;

    modport master (
        output IF_valid,
        output IF_inst,
        output IF_pc,
        output ID_enable,
        input  queue_is_full,
        input  queue_almost_full,
        input  queue_is_empty,
        input  ID_inst,
        input  ID_pc,
        input  queue_count
    );

    modport slave (
        input  IF_valid,
        input  IF_inst,
        input  IF_pc,
        input  ID_enable,
        output queue_is_full,
        output queue_almost_full,
        output queue_is_empty,
        output ID_inst,
        output ID_pc,
        output queue_count
    );
endinterface

// File: rtl/inst_queue.sv
// Circular IF->ID instruction FIFO with show-ahead head,
// global stall (rdy) and ROB flush (clear).
module inst_queue #(
    parameter int DEPTH       = 16,
    parameter int PTR_W       = 4,
    parameter int AFULL_SLACK = 2
) (
    input logic         clk,
    input logic         rst,
    input logic         rdy,
    input logic         clear,
    inst_queue_if.slave iq
);
    localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] AFULL_CNT = (PTR_W+1)'(DEPTH - AFULL_SLACK);

    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Flags come from the current count, so a full queue drops
    // a same-cycle push and an empty queue drops a same-cycle pop.
    assign push = rdy && !clear && iq.IF_valid && !full;
    assign pop  = rdy && !clear && iq.ID_enable && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (clear) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push)
                    tail <= tail + 1'b1;
                if (pop)
                    head <= head + 1'b1;
                count <= count
                       + {{PTR_W{1'b0}}, push}
                       - {{PTR_W{1'b0}}, pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[tail] <= iq.IF_inst;
            pc_mem[tail]   <= iq.IF_pc;
        end
    end

    // An empty queue never exposes a stale entry to decode.
    assign iq.ID_inst = empty ? '0 : inst_mem[head];
    assign iq.ID_pc   = empty ? '0 : pc_mem[head];

    assign iq.queue_is_full     = full;
    assign iq.queue_is_empty    = empty;
    assign iq.queue_almost_full = (count >= AFULL_CNT);
    assign iq.queue_count       = count;
endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: directed stimulus,
// negedge monitor compares head data and flags.
module tb_inst_queue;
    logic clk;
    logic rst;
    logic rdy;
    logic clear;

    inst_queue_if #(.PTR_W(4)) iq ();

    inst_queue #(
        .DEPTH(16),
        .PTR_W(4),
        .AFULL_SLACK(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .clear(clear),
        .iq(iq)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, got, exp, $time);
        end
    endtask

    always @(negedge rst) sb.delete();

    // State is compared before this cycle's edge is modelled.
    always @(negedge clk) begin
        if (rst) begin
            chk("count", 32'(iq.queue_count), 32'(sb.size()));
            chk("empty", 32'(iq.queue_is_empty),
                32'(sb.size() == 0));
            chk("full", 32'(iq.queue_is_full),
                32'(sb.size() == 16));
            chk("afull", 32'(iq.queue_almost_full),
                32'(sb.size() >= 14));
            if (sb.size() == 0) begin
                chk("empty_inst", iq.ID_inst, 32'h0);
                chk("empty_pc", iq.ID_pc, 32'h0);
            end
            if (rdy) begin
                if (clear) begin
                    sb.delete();
                end else begin
                    automatic bit do_push =
                        iq.IF_valid && sb.size() < 16;
                    if (iq.ID_enable && sb.size() > 0) begin
                        chk("head_inst", iq.ID_inst, sb[0].inst);
                        chk("head_pc", iq.ID_pc, sb[0].pc);
                        void'(sb.pop_front());
                    end
                    if (do_push)
                        sb.push_back({iq.IF_inst, iq.IF_pc});
                end
            end
        end
    end

    task automatic drive(input logic v, input logic en,
                         input logic c, input logic r,
                         input logic [31:0] i,
                         input logic [31:0] p);
        iq.IF_valid  = v;
        iq.ID_enable = en;
        clear        = c;
        rdy          = r;
        iq.IF_inst   = i;
        iq.IF_pc     = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        iq.IF_valid  = 1'b0;
        iq.ID_enable = 1'b0;
        clear        = 1'b0;
        rdy          = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        idle_in();
        iq.IF_inst = '0;
        iq.IF_pc   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rst_count", 32'(iq.queue_count), 32'd0);
        chk("rst_empty", 32'(iq.queue_is_empty), 32'd1);
        chk("rst_full", 32'(iq.queue_is_full), 32'd0);
        chk("rst_afull", 32'(iq.queue_almost_full), 32'd0);

        // fill
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 0, 1, 32'h13 + 32'(i), 32'(4 * i));
            if (i == 12)
                chk("afull_13", 32'(iq.queue_almost_full), 32'd0);
            if (i == 13)
                chk("afull_14", 32'(iq.queue_almost_full), 32'd1);
            if (i == 14)
                chk("full_15", 32'(iq.queue_is_full), 32'd0);
        end
        chk("full_16", 32'(iq.queue_is_full), 32'd1);
        chk("count_16", 32'(iq.queue_count), 32'd16);
        chk("head_first", iq.ID_pc, 32'd0);
        drive(1, 0, 0, 1, 32'hdead_beef, 32'hbeef);
        chk("count_ovf", 32'(iq.queue_count), 32'd16);

        // drain
        for (int i = 0; i < 16; i++)
            drive(0, 1, 0, 1, 32'h0, 32'h0);
        chk("drain_empty", 32'(iq.queue_is_empty), 32'd1);
        chk("drain_inst", iq.ID_inst, 32'h0);
        chk("drain_pc", iq.ID_pc, 32'h0);
        drive(0, 1, 0, 1, 32'h0, 32'h0);
        chk("underflow", 32'(iq.queue_count), 32'd0);

        // empty push+pop: only the push lands
        drive(1, 1, 0, 1, 32'h300, 32'h3000);
        chk("ep_count", 32'(iq.queue_count), 32'd1);
        chk("ep_pc", iq.ID_pc, 32'h3000);
        drive(0, 1, 0, 1, 32'h0, 32'h0);

        // steady push+pop at depth 3, wrapping pointers
        for (int k = 0; k < 3; k++)
            drive(1, 0, 0, 1, 32'h200 + 32'(k),
                  32'h1000 + 32'(4 * k));
        for (int k = 3; k < 43; k++)
            drive(1, 1, 0, 1, 32'h200 + 32'(k),
                  32'h1000 + 32'(4 * k));
        chk("wrap_count", 32'(iq.queue_count), 32'd3);
        chk("wrap_head", iq.ID_pc, 32'h1000 + 32'(4 * 40));

        for (int k = 43; k < 56; k++)
            drive(1, 0, 0, 1, 32'h200 + 32'(k),
                  32'h1000 + 32'(4 * k));
        chk("refull", 32'(iq.queue_count), 32'd16);
        drive(1, 1, 0, 1, 32'h0bad, 32'h0bad);
        chk("full_pp", 32'(iq.queue_count), 32'd15);

        // flush
        for (int k = 0; k < 8; k++)
            drive(0, 1, 0, 1, 32'h0, 32'h0);
        chk("pre_flush", 32'(iq.queue_count), 32'd7);
        drive(1, 1, 1, 1, 32'h0bad_0bad, 32'h0bad);
        chk("flush_cnt", 32'(iq.queue_count), 32'd0);
        chk("flush_empty", 32'(iq.queue_is_empty), 32'd1);
        chk("flush_pc", iq.ID_pc, 32'h0);
        drive(1, 0, 0, 1, 32'h4000_0013, 32'h8000);
        chk("post_inst", iq.ID_inst, 32'h4000_0013);
        chk("post_pc", iq.ID_pc, 32'h8000);

        // stall
        for (int k = 1; k < 5; k++)
            drive(1, 0, 0, 1, 32'h500 + 32'(k),
                  32'h8000 + 32'(4 * k));
        chk("pre_stall", 32'(iq.queue_count), 32'd5);
        for (int k = 0; k < 4; k++) begin
            drive(k[0], ~k[0], k[1], 0, 32'hffff, 32'hffff);
            chk("stall_cnt", 32'(iq.queue_count), 32'd5);
            chk("stall_pc", iq.ID_pc, 32'h8000);
        end
        drive(0, 1, 0, 1, 32'h0, 32'h0);
        chk("resume_cnt", 32'(iq.queue_count), 32'd4);
        chk("resume_pc", iq.ID_pc, 32'h8004);

        // async reset mid-stream
        for (int k = 0; k < 5; k++)
            drive(1, 0, 0, 1, 32'h600 + 32'(k),
                  32'h9000 + 32'(4 * k));
        chk("pre_rst", 32'(iq.queue_count), 32'd9);
        idle_in();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_empty", 32'(iq.queue_is_empty), 32'd1);
        chk("arst_count", 32'(iq.queue_count), 32'd0);
        chk("arst_inst", iq.ID_inst, 32'h0);
        rst = 1'b1;
        drive(0, 0, 0, 1, 32'h0, 32'h0);
        chk("arst_hold", iq.ID_pc, 32'h0);
        drive(1, 0, 0, 1, 32'h700, 32'h7000);
        chk("arst_push", iq.ID_pc, 32'h7000);
        drive(0, 1, 0, 1, 32'h0, 32'h0);
        drive(0, 0, 0, 1, 32'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
